scan_chain_seq: RTL and testbench

- Scan test sequencer that drives the SE/SI inputs of one scan chain built from sdffq-class scan flops, and consumes the chain's serial output (Q of the last flop).
- Loads a parallel pattern serially, fires one capture cycle, unloads the captured response and compares it against an expected vector.
- Sits between the on-chip test controller (parallel pattern/expect registers) and the chain itself.

---
 rtl/scan_chain_seq_if.sv | 35 +++
 rtl/scan_chain_seq.sv | 138 +++++++++++++
 tb/tb_scan_chain_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_seq_if.sv
// Bus between the test controller/scan chain and the scan_chain_seq sequencer.
// SIG exists only when SCAN_CHAIN_SEQ_SISR_EN is defined.
interface scan_chain_seq_if #(
    parameter int CHAIN_LEN = 16
);
    logic                 START;
    logic [CHAIN_LEN-1:0] PAT_IN;
    logic [CHAIN_LEN-1:0] EXP_IN;
    logic                 SO;
    logic                 SE;
    logic                 SI;
    logic                 BUSY;
    logic                 DONE;
    logic                 PASS;
    logic [CHAIN_LEN-1:0] CAP_OUT;
`ifdef SCAN_CHAIN_SEQ_SISR_EN
    logic [15:0]          SIG;
`endif

    modport master (
        output START, PAT_IN, EXP_IN, SO,
`ifdef SCAN_CHAIN_SEQ_SISR_EN
        input  SIG,
`endif
        input  SE, SI, BUSY, DONE, PASS, CAP_OUT
    );

    modport slave (
        input  START, PAT_IN, EXP_IN, SO,
`ifdef SCAN_CHAIN_SEQ_SISR_EN
        output SIG,
`endif
        output SE, SI, BUSY, DONE, PASS, CAP_OUT
    );
endinterface

// File: rtl/scan_chain_seq.sv
// Scan sequencer: serial load, one capture cycle, serial unload and compare.
// Optional serial signature register enabled by defining SCAN_CHAIN_SEQ_SISR_EN.
module scan_chain_seq #(
    parameter int CHAIN_LEN = 16
) (
    input logic           CLK,
    input logic           RST,
    scan_chain_seq_if.slave bus
);
    localparam int CNT_W = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_CAPTURE,
        ST_SHIFT_OUT,
        ST_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] cap_q, cap_d;
    logic                 pass_q, pass_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        exp_d   = exp_q;
        cap_d   = cap_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    pat_d   = bus.PAT_IN;
                    exp_d   = bus.EXP_IN;
                    cap_d   = '0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT_IN;
                end
            end
            ST_SHIFT_IN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: state_d = ST_SHIFT_OUT;
            ST_SHIFT_OUT: begin
                // SO still shows the bit that this edge's shift will push out.
                cap_d[cnt_q] = bus.SO;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    pass_d  = (cap_d == exp_q);
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Chain controls are registered from next-state so they never glitch on START/SO.
        se_d   = (state_d == ST_SHIFT_IN) || (state_d == ST_SHIFT_OUT);
        si_d   = (state_d == ST_SHIFT_IN) && pat_d[cnt_d];
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            exp_q   <= '0;
            cap_q   <= '0;
            pass_q  <= 1'b0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            pass_q  <= pass_d;
            se_q    <= se_d;
            si_q    <= si_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.SE      = se_q;
    assign bus.SI      = si_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.PASS    = pass_q;
    assign bus.CAP_OUT = cap_q;

`ifdef SCAN_CHAIN_SEQ_SISR_EN
    logic [15:0] sig_q, sig_d;
    logic        sig_fb;

    always_comb begin
        sig_d  = sig_q;
        sig_fb = sig_q[15] ^ bus.SO;
        if ((state_q == ST_IDLE) && bus.START) begin
            sig_d = '0;
        end else if (state_q == ST_SHIFT_OUT) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_fb ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign bus.SIG = sig_q;
`endif
endmodule

// File: tb/tb_scan_chain_seq.sv
// Bench for scan_chain_seq: behavioural chain + cycle-indexed reference of one run.
module tb_scan_chain_seq;
    localparam int N = 16;

    logic clk;
    logic rst;
    int   mode;       // 0 hold-capture, 1 capture ones, 2 SO=1 on last unload cycle, 3 SO=0
    logic so_force;

    scan_chain_seq_if #(.CHAIN_LEN(N)) bus ();

    scan_chain_seq #(.CHAIN_LEN(N)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scan chain: bit 0 is chain position 0, bit N-1 drives SO.
    logic [N-1:0] chain = '0;
    always @(posedge clk) begin
        if (bus.SE === 1'b1)  chain <= {chain[N-2:0], bus.SI};
        else if (mode == 1)   chain <= '1;
    end
    assign bus.SO = (mode >= 2) ? so_force : chain[N-1];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // What the chain hands back after a full load + capture, per chain behaviour.
    function automatic logic [N-1:0] cap_model(input int md, input logic [N-1:0] pat);
        case (md)
            0:       return pat;
            1:       return '1;
            2:       return {1'b1, {(N-1){1'b0}}};
            default: return '0;
        endcase
    endfunction

    function automatic logic [15:0] sisr(input logic [N-1:0] bits);
        logic [15:0] s;
        logic        fb;
        s = '0;
        for (int k = 0; k < N; k++) begin
            fb = s[15] ^ bits[k];
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    // Reference: m_c counts edges since the accepting START edge.
    bit           chk_en = 0;
    bit           m_active = 0;
    int           m_c = 0;
    int           m_mode = 0;
    logic [N-1:0] m_pat = '0;
    logic [N-1:0] m_exp = '0;
    logic [N-1:0] m_cap = '0;
    logic         m_pass = 1'b0;
    logic [15:0]  m_sig = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_c = 0; m_cap = '0; m_pass = 1'b0; m_sig = '0; chk_en = 1;
        end else if (!m_active) begin
            if (bus.START === 1'b1) begin
                m_active = 1; m_c = 0; m_mode = mode;
                m_pat = bus.PAT_IN; m_exp = bus.EXP_IN;
                m_cap = '0; m_pass = 1'b0; m_sig = '0;
            end
        end else if (m_c == 2*N+1) begin
            m_active = 0;
        end else begin
            m_c++;
            if (m_c == 2*N+1) begin
                m_cap  = cap_model(m_mode, m_pat);
                m_pass = (m_cap == m_exp);
                m_sig  = sisr(m_cap);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (m_active) begin
                chk("se", bus.SE, (m_c < N) || (m_c >= N+1 && m_c <= 2*N));
                chk("si", bus.SI, (m_c < N) ? m_pat[m_c] : 1'b0);
                chk("busy", bus.BUSY, 1'b1);
                chk("done", bus.DONE, m_c == 2*N+1);
                chk("pass", bus.PASS, m_pass);
                if (m_c == 2*N+1) begin
                    chk("cap_out", bus.CAP_OUT, m_cap);
`ifdef SCAN_CHAIN_SEQ_SISR_EN
                    chk("sig", bus.SIG, m_sig);
`endif
                end
            end else begin
                chk("se_idle", bus.SE, 1'b0);
                chk("si_idle", bus.SI, 1'b0);
                chk("busy_idle", bus.BUSY, 1'b0);
                chk("done_idle", bus.DONE, 1'b0);
                chk("pass_idle", bus.PASS, m_pass);
                chk("cap_idle", bus.CAP_OUT, m_cap);
`ifdef SCAN_CHAIN_SEQ_SISR_EN
                chk("sig_idle", bus.SIG, m_sig);
`endif
            end
            if (bus.DONE === 1'b1) done_cnt++;
        end
    end

    int run_id = 0;

    task automatic run_seq(input logic [N-1:0] pat, input logic [N-1:0] expv, input int md,
                           input bit poke, input bit abort,
                           input logic [N-1:0] lit_cap, input logic lit_pass,
                           input bit chk_sig, input logic [15:0] lit_sig);
        int c;
        int se_cnt;
        int d0;
        bit aborted;
        run_id++;
        d0 = done_cnt; aborted = 0; se_cnt = 0;
        mode = md; so_force = 1'b0;
        @(negedge clk);
        bus.PAT_IN = pat; bus.EXP_IN = expv; bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0; bus.PAT_IN = ~pat; bus.EXP_IN = ~expv;
        c = 0;
        while (bus.DONE !== 1'b1 && c < 200) begin
            se_cnt += int'(bus.SE);
            if (c == N) chk("se_low_capture", bus.SE, 1'b0);
            bus.START = poke && (c == 5);
            so_force  = (md == 2) && (c == 2*N);
            if (abort && c == N+6) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_se", bus.SE, 1'b0);
                chk("abort_busy", bus.BUSY, 1'b0);
                chk("abort_cap", bus.CAP_OUT, '0);
                chk("abort_pass", bus.PASS, 1'b0);
                rst = 1'b0;
                aborted = 1;
                break;
            end
            @(negedge clk);
            c++;
        end
        so_force = 1'b0;
        bus.START = 1'b0;
        if (aborted) begin
            repeat (4) @(negedge clk);
            chk("abort_no_done", done_cnt - d0, 0);
            $display("run %0d pat=%h aborted at unload bit 5, done_pulses=%0d", run_id, pat, done_cnt - d0);
        end else begin
            chk("done_latency", c, 2*N+1);
            chk("se_high_cycles", se_cnt, 2*N);
            chk("cap_literal", bus.CAP_OUT, lit_cap);
            chk("pass_literal", bus.PASS, lit_pass);
`ifdef SCAN_CHAIN_SEQ_SISR_EN
            if (chk_sig) chk("sig_literal", bus.SIG, lit_sig);
`else
            if (chk_sig) chk("sig_flag_unused", lit_sig, lit_sig ^ 16'h0);
`endif
            if (poke) bus.START = 1'b1;
            @(negedge clk);
            bus.START = 1'b0;
            repeat (3) @(negedge clk);
            chk("done_pulses", done_cnt - d0, 1);
            chk("cap_held", bus.CAP_OUT, lit_cap);
            $display("run %0d pat=%h exp=%h cap=%h pass=%b done_edge=%0d done_pulses=%0d",
                     run_id, pat, expv, bus.CAP_OUT, bus.PASS, c, done_cnt - d0);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 0; so_force = 1'b0;
        bus.START = 1'b0; bus.PAT_IN = '0; bus.EXP_IN = '0;
        repeat (3) @(negedge clk);
        chk("reset_se", bus.SE, 1'b0);
        chk("reset_busy", bus.BUSY, 1'b0);
        chk("reset_cap", bus.CAP_OUT, '0);
        rst = 1'b0;
        @(negedge clk);

        run_seq(16'h1234, 16'h1234, 0, 0, 0, 16'h1234, 1'b1, 0, 16'h0000);
        run_seq(16'h1234, 16'h1235, 0, 0, 0, 16'h1234, 1'b0, 0, 16'h0000);
        run_seq(16'h0000, 16'hFFFF, 1, 0, 0, 16'hFFFF, 1'b1, 0, 16'h0000);
        run_seq(16'hA5C3, 16'hA5C3, 0, 1, 0, 16'hA5C3, 1'b1, 0, 16'h0000);
        run_seq(16'hFFFF, 16'hFFFF, 0, 0, 1, 16'h0000, 1'b0, 0, 16'h0000);
        run_seq(16'h8001, 16'h8001, 0, 0, 0, 16'h8001, 1'b1, 0, 16'h0000);
`ifdef SCAN_CHAIN_SEQ_SISR_EN
        run_seq(16'h0000, 16'h8000, 2, 0, 0, 16'h8000, 1'b1, 1, 16'h1021);
        run_seq(16'h0000, 16'h0000, 3, 0, 0, 16'h0000, 1'b1, 1, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
